// File: rtl/marc_mem_seq.sv
// marc_mem_seq: program memory and run sequencer for the mARC Processor.
// The host loads a program while the CPU is held in reset. host_start releases
// the CPU, which then fetches through cpu_dataIn and stores through cpu_rw.
// A run ends when the CPU stores to HALT_ADDR.
// Optional feature macro: MARC_WATCHDOG_EN adds a RUN-cycle watchdog that ends
// the run with timeout=1 once cycle_count reaches WDOG_LIMIT.
module marc_mem_seq #(
    parameter int          ADDR_W     = 12,
    parameter logic [15:0] HALT_ADDR  = 16'hFFFF,
    parameter logic [31:0] WDOG_LIMIT = 32'd100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [15:0]       host_wdata,
    output logic [15:0]       host_rdata,
    input  logic              host_start,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [31:0]       cycle_count,
    output logic              cpu_reset,
    output logic [15:0]       cpu_dataIn,
    input  logic [15:0]       cpu_busA,
    input  logic [15:0]       cpu_busB,
    input  logic              cpu_rw
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] RESET_VEC = '0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Elaboration-time sanity: the CPU bus is 16 bits wide, and a zero watchdog
    // limit would end every run before the first instruction executes.
    if (ADDR_W < 1 || ADDR_W > 16) begin : g_bad_addr_w
        $error("marc_mem_seq: ADDR_W must be in 1..16");
    end
    if (WDOG_LIMIT == 32'd0) begin : g_bad_wdog_limit
        $error("marc_mem_seq: WDOG_LIMIT must be nonzero");
    end

    state_t            state_q, state_d;
    logic [15:0]       mem [DEPTH];
    logic [15:0]       host_rdata_q;
    logic [15:0]       cpu_data_q;
    logic [31:0]       cycle_count_q, cycle_count_d;

    logic              host_side;     // host owns the memory port (IDLE/DONE)
    logic              in_run;
    logic              in_release;
    logic              cpu_in_range;
    logic [ADDR_W-1:0] cpu_addr;
    logic              halt_hit;
    logic              wdog_hit;
    logic              host_wr;
    logic              cpu_wr;

    assign host_side  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign in_run     = (state_q == S_RUN);
    assign in_release = (state_q == S_RELEASE);
    assign cpu_addr   = cpu_busA[ADDR_W-1:0];

    // The upper address bits must be zero for an access to hit memory; with a
    // full 16-bit memory every address is in range.
    if (ADDR_W < 16) begin : g_range
        assign cpu_in_range = (cpu_busA[15:ADDR_W] == '0);
    end else begin : g_range_full
        assign cpu_in_range = 1'b1;
    end

    // A halt store never writes memory, even if HALT_ADDR happens to be in range.
    assign halt_hit = in_run && cpu_rw && (cpu_busA == HALT_ADDR);
    assign cpu_wr   = in_run && cpu_rw && cpu_in_range && !halt_hit;
    assign host_wr  = host_side && host_we;

`ifdef MARC_WATCHDOG_EN
    logic timeout_q;

    // Halt has priority over the watchdog when both land on the same edge.
    assign wdog_hit = in_run && (cycle_count_q >= WDOG_LIMIT) && !halt_hit;

    // Timeout flag: cleared when a new run is released, set when the watchdog fires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_q <= 1'b0;
        end else if (in_release) begin
            timeout_q <= 1'b0;
        end else if (wdog_hit) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    assign wdog_hit = 1'b0;
    assign timeout  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (host_start) state_d = S_RELEASE;
            S_RELEASE: state_d = S_RUN;
            S_RUN:     if (halt_hit || wdog_hit) state_d = S_DONE;
            S_DONE:    if (host_start) state_d = S_RELEASE;
            default:   state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs: the CPU is held in reset everywhere except RUN.
    always_comb begin
        cpu_reset = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            S_IDLE:    ;
            S_RELEASE: busy = 1'b1;
            S_RUN: begin
                busy      = 1'b1;
                cpu_reset = 1'b0;
            end
            S_DONE:    done = 1'b1;
            default:   ;
        endcase
    end

    // Run-cycle counter: zeroed on release, counts every RUN edge, saturates.
    always_comb begin
        cycle_count_d = cycle_count_q;
        if (in_release) begin
            cycle_count_d = '0;
        end else if (in_run && (cycle_count_q != '1)) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
        end
    end

    // Single write port: host owns it in IDLE/DONE, the CPU in RUN. Not reset,
    // so a program survives a mid-run reset.
    always_ff @(posedge clk) begin
        if (host_wr) begin
            mem[host_addr] <= host_wdata;
        end else if (cpu_wr) begin
            mem[cpu_addr] <= cpu_busB;
        end
    end

    // Host readback: registered read of the old contents, frozen while the CPU runs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            host_rdata_q <= '0;
        end else if (host_side) begin
            host_rdata_q <= mem[host_addr];
        end
    end

    // CPU fetch: the release cycle preloads word 0 so the first instruction is
    // ready when reset drops; out-of-range reads return 0; holds outside RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_data_q <= '0;
        end else if (in_release) begin
            cpu_data_q <= mem[RESET_VEC];
        end else if (in_run) begin
            cpu_data_q <= cpu_in_range ? mem[cpu_addr] : 16'h0000;
        end
    end

    assign host_rdata  = host_rdata_q;
    assign cpu_dataIn  = cpu_data_q;
    assign cycle_count = cycle_count_q;

endmodule
